// File: rtl/ard_frame_rx.sv
// Serial receiver for the Arduino 11-bit instruction word (sclk/sdata/cs_n). It
// checks framing and presents good frames with a one-cycle strobe. Optional macro: ARD_FRAME_PARITY_EN.
module ard_frame_rx #(
    parameter int FRAME_W     = 11,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ard_sclk,
    input  logic               ard_sdata,
    input  logic               ard_cs_n,
    output logic [FRAME_W-1:0] instruct,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               busy
);

`ifdef ARD_FRAME_PARITY_EN
    localparam int SR_W = FRAME_W + 1;
`else
    localparam int SR_W = FRAME_W;
`endif
    localparam int CNT_W = $clog2(SR_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END, DRAIN} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q, cs_sync_q, vld_q;
    logic                   sclk_dly_q, cs_dly_q, armed_q;
    logic                   sclk_s, sdata_s, cs_s;
    logic                   sclk_rise, cs_rise, cs_fall;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [FRAME_W-1:0] instruct_q, instruct_d;
    logic               valid_q, valid_d, err_q, err_d, busy_q;
    logic [FRAME_W-1:0] frame_word;
    logic               par_bad;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];

    // A cs_n low already present at reset release must not open a frame, so
    // falling edges count only after cs_n has been genuinely observed high.
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q & armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            cs_sync_q    <= '1;
            sclk_dly_q   <= 1'b0;
            cs_dly_q     <= 1'b1;
            vld_q        <= '0;
            armed_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, which is what turns this into a real shift chain.
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], ard_sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], ard_sdata};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], ard_cs_n};
            sclk_dly_q   <= sclk_s;
            cs_dly_q     <= cs_s;
            vld_q        <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            armed_q      <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end

`ifdef ARD_FRAME_PARITY_EN
    assign frame_word = shift_q[SR_W-1:1];
    assign par_bad    = ^shift_q;
`else
    assign frame_word = shift_q;
    assign par_bad    = 1'b0;
`endif

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        instruct_d = instruct_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                    to_d    = '0;
                end
            end
            SHIFT: begin
                to_d = sclk_rise ? '0 : to_q + 1'b1;
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[SR_W-2:0], sdata_s};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = WAIT_END;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            WAIT_END: begin
                to_d = sclk_rise ? '0 : to_q + 1'b1;
                if (cs_rise) begin
                    state_d = IDLE;
                    if (par_bad) begin
                        err_d = 1'b1;
                    end else begin
                        instruct_d = frame_word;
                        valid_d    = 1'b1;
                    end
                end else if (sclk_rise || to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            to_q       <= '0;
            instruct_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            instruct_q <= instruct_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= (state_q != IDLE);
        end
    end

    assign instruct    = instruct_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ard_frame_rx.sv
// Scoreboard bench for ard_frame_rx: stimulus queues expected frame events, a
// negedge monitor pops and compares them whenever frame_valid or frame_err pulses.
module tb_ard_frame_rx;

    localparam int FRAME_W     = 11;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 64;
`ifdef ARD_FRAME_PARITY_EN
    localparam int NB = FRAME_W + 1;
`else
    localparam int NB = FRAME_W;
`endif

    typedef struct {
        bit                 is_err;
        logic [FRAME_W-1:0] instr;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ard_sclk = 1'b0;
    logic               ard_sdata = 1'b0;
    logic               ard_cs_n = 1'b1;
    logic [FRAME_W-1:0] instruct;
    logic               frame_valid, frame_err, busy;

    exp_t               exp_q[$];
    logic [FRAME_W-1:0] model_instr = '0;
    int                 checks = 0;
    int                 failures = 0;
    int                 cyc = 0;
    int                 last_rise = 0;
    int                 err_cyc = 0;
    bit                 err_seen = 1'b0;

    ard_frame_rx #(
        .FRAME_W    (FRAME_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ard_sclk   (ard_sclk),
        .ard_sdata  (ard_sdata),
        .ard_cs_n   (ard_cs_n),
        .instruct   (instruct),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] enc(input logic [FRAME_W-1:0] d);
`ifdef ARD_FRAME_PARITY_EN
        return {4'b0, d, ^d};
`else
        return {5'b0, d};
`endif
    endfunction

    task automatic push(input bit is_err);
        exp_t e;
        e.is_err = is_err;
        e.instr  = model_instr;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ard_sdata = bits[i];
            tick(4);
            ard_sclk  = 1'b1;
            last_rise = cyc;
            tick(4);
            ard_sclk  = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] bits, input int n);
        ard_cs_n = 1'b0;
        tick(4);
        send_bits(bits, n);
        tick(4);
        ard_cs_n = 1'b1;
        tick(8);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_err)) begin
            check("valid_err_exclusive", {31'b0, frame_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b instr=%0h expected none",
                         frame_valid, frame_err, instruct);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind_err", {31'b0, frame_err}, {31'b0, e.is_err});
                check("event_instr", {21'b0, instruct}, {21'b0, e.instr});
            end
            if (frame_err) begin
                err_seen = 1'b1;
                err_cyc  = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;
        int lat;
        tick(3);
        check("rst_instr", {21'b0, instruct}, 32'd0);
        check("rst_valid", {31'b0, frame_valid}, 32'd0);
        check("rst_err", {31'b0, frame_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick(6);

        // 1: good frame, with busy observed mid-frame and after
        model_instr = 11'h49D;
        push(1'b0);
        ard_cs_n = 1'b0;
        tick(4);
        send_bits(enc(11'h49D), NB);
        check("busy_in_frame", {31'b0, busy}, 32'd1);
        tick(4);
        ard_cs_n = 1'b1;
        tick(8);
        check("busy_after_good", {31'b0, busy}, 32'd0);

        // 2: short frame keeps the previous word
        push(1'b1);
        frame(16'h0055, 7);

        // 3: overrun on the edge after the last expected bit
        push(1'b1);
        frame(16'hFFFF, NB + 1);
        check("busy_after_overrun", {31'b0, busy}, 32'd0);

        // 4: timeout after 5 bits, then recovery
        push(1'b1);
        ard_cs_n = 1'b0;
        tick(4);
        err_seen = 1'b0;
        send_bits(16'h0016, 5);
        for (int i = 0; i < 150 && !err_seen; i++) tick(1);
        diff = err_cyc - last_rise;
        lat  = TIMEOUT_CYC + SYNC_STAGES + 1;
        checks++;
        if (!err_seen || diff < lat - 1 || diff > lat + 1) begin
            failures++;
            $display("FAIL timeout_latency: got seen=%0b cycles=%0d expected %0d+-1",
                     err_seen, diff, lat);
        end
        tick(10);
        check("busy_in_drain", {31'b0, busy}, 32'd1);
        ard_cs_n = 1'b1;
        tick(8);
        check("busy_after_drain", {31'b0, busy}, 32'd0);
        model_instr = 11'h2A5;
        push(1'b0);
        frame(enc(11'h2A5), NB);

        // 5: reset mid-frame, cs_n still low on release must not be accepted
        ard_cs_n = 1'b0;
        tick(4);
        send_bits(enc(11'h7FF) >> (NB - 6), 6);
        rst = 1'b1;
        #1;
        check("midrst_instr", {21'b0, instruct}, 32'd0);
        check("midrst_valid", {31'b0, frame_valid}, 32'd0);
        check("midrst_err", {31'b0, frame_err}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        model_instr = '0;
        tick(3);
        rst = 1'b0;
        send_bits(enc(11'h7FF), NB - 6);
        check("busy_stale_frame", {31'b0, busy}, 32'd0);
        tick(4);
        ard_cs_n = 1'b1;
        tick(8);
        check("instr_stale_frame", {21'b0, instruct}, 32'd0);
        model_instr = 11'h7FF;
        push(1'b0);
        frame(enc(11'h7FF), NB);

`ifdef ARD_FRAME_PARITY_EN
        // 6: parity good then bad
        model_instr = 11'h49D;
        push(1'b0);
        frame({4'b0, 11'h49D, 1'b0}, NB);
        push(1'b1);
        frame({4'b0, 11'h49D, 1'b1}, NB);
`endif

        tick(20);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ard_frame_rx.md
Name: ard_frame_rx

Overview:
Serial front end that receives the 11-bit instruction word from the Arduino over a 3-wire link (sclk, sdata, cs_n). It deserializes the word and checks framing. Each good frame is presented as a parallel word plus a one-cycle valid strobe to the instruction decoder/register stage, which splits it into num1[10:7], num2[6:3], oper[2:1] and Ain[0]. Malformed frames are dropped and flagged.

Parameters:
FRAME_W, 11, payload bits per frame, sent MSB first.
SYNC_STAGES, 2, synchronizer flops per async input (min 2).
TIMEOUT_CYC, 1024, clk cycles without an sclk edge before an open frame is aborted.

Ports:
clk  in  1  system clock; must be >= 4x sclk frequency.
rst  in  1  asynchronous reset, active-high.
ard_sclk  in  1  Arduino serial clock (async); data sampled on its rising edge.
ard_sdata  in  1  Arduino serial data (async).
ard_cs_n  in  1  frame select, active-low (async); low for the whole frame.
instruct  out  FRAME_W  last good frame; held between frames.
frame_valid  out  1  one-cycle pulse when instruct is updated.
frame_err  out  1  one-cycle pulse on a dropped frame.
busy  out  1  high while a frame is open (state != IDLE).

Behaviour:
- Reset: instruct=0, frame_valid=0, frame_err=0, busy=0, state=IDLE, shift reg=0, bit count=0, timeout count=0. Sync flops reset to idle line levels: sclk=0, sdata=0, cs_n=1.
- All three inputs pass through SYNC_STAGES flops. Edge detection uses the synced value and a 1-flop delayed copy.
- States: IDLE, SHIFT, WAIT_END, DRAIN.
- IDLE: a synced cs_n falling edge -> SHIFT; clear shift reg, bit count and timeout count. sclk edges in IDLE are ignored.
- SHIFT: on each synced sclk rising edge, shift reg <= {shift[W-2:0], sdata_sync} and bit count++.
  - When bit count reaches FRAME_W -> WAIT_END.
  - cs_n rising edge before FRAME_W bits -> pulse frame_err, instruct unchanged -> IDLE.
- WAIT_END: on cs_n rising edge, instruct <= shift reg and pulse frame_valid in the same cycle -> IDLE.
  - An sclk rising edge here is an overrun: pulse frame_err -> DRAIN.
- DRAIN: ignore sclk and data; on synced cs_n high -> IDLE. No further error pulses for the same frame.
- Timeout: in SHIFT or WAIT_END, the counter increments each clk and clears on every sclk rising edge. On reaching TIMEOUT_CYC, pulse frame_err -> DRAIN.
- Simultaneous events in one clk: a cs_n rising edge has priority over an sclk rising edge, and the sclk edge is discarded. A cs_n falling edge while in DRAIN is ignored until cs_n has been seen high.
- Latency: frame_valid asserts SYNC_STAGES+2 clk cycles after the raw cs_n rise (tolerance ±1 cycle for async sampling).
- instruct changes only on the frame_valid cycle. frame_valid and frame_err are never high in the same cycle.
- busy = (state != IDLE). It is registered and goes low the cycle after the return to IDLE.
- Reset mid-frame: everything returns to reset values immediately and the partial frame is lost. After reset release, a frame whose cs_n is already low is not accepted; the next cs_n falling edge starts a new frame.

Optional Feature:
ARD_FRAME_PARITY_EN
- Defined: each frame carries FRAME_W+1 bits, with an even-parity bit sent last.
  - SHIFT leaves after FRAME_W+1 bits.
  - In WAIT_END, on cs_n rise: if the XOR of all FRAME_W+1 bits is 1, pulse frame_err and keep instruct; otherwise update instruct and pulse frame_valid.
  - The parity bit is never stored in instruct.
- Undefined: no parity bit, no parity logic, behaviour exactly as above.

Test Plan:
1. Good frame: cs_n low, send 11'b10010011101 (0x49D) MSB first, cs_n high -> one frame_valid pulse, instruct=0x49D, frame_err=0, busy low afterwards.
2. Short frame: send 7 bits, raise cs_n -> single frame_err pulse, no frame_valid, instruct stays at the previous value (0x49D).
3. Overrun: send 12 sclk edges in one cs_n window -> frame_err on the 12th edge, no frame_valid on cs_n rise, busy drops after cs_n high.
4. Timeout (TIMEOUT_CYC=64): send 5 bits, then hold sclk -> frame_err exactly 64 cycles after the last synced edge. State stays DRAIN until cs_n high, then the next good frame 0x2A5 is accepted.
5. Reset mid-frame: assert rst after 6 bits -> all outputs 0 on the same cycle. After release, a new full frame 0x7FF gives instruct=0x7FF.
6. With ARD_FRAME_PARITY_EN: 0x49D plus parity 0 -> valid, instruct=0x49D. Then 0x49D plus parity 1 -> frame_err, instruct stays 0x49D.
